// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one start bit, NB_DATA data
// bits, one stop bit spanning SB_TICK ticks. The serial input is
// synchronized before use. The receiver reports a good word with
// o_rx_done and a low stop bit with o_frame_error.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int N_SYNC  = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rate,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error
);

    localparam int              BW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [3:0]      MID_TICK = 4'd7;
    localparam logic [3:0]      BIT_TICK = 4'd15;
    localparam logic [3:0]      SB_LAST  = 4'(SB_TICK - 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(NB_DATA - 1);
    localparam logic [BW-1:0]   BIT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [N_SYNC-1:0]  sync_q;
    logic               rx_s;
    state_t             state_q;
    logic [3:0]         tick_q;
    logic [BW-1:0]      bit_q;
    logic [NB_DATA-1:0] shift_q;

    assign rx_s = sync_q[N_SYNC-1];

    // Synchronizer chain for the asynchronous line; stages reset to the idle level.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= i_rx;
            for (int i = 1; i < N_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Frame FSM with tick/bit counters, shift register and registered pulses.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            // Pulses are high for a single cycle unless re-asserted below.
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Ticks are ignored here; only a low line starts a frame.
                    tick_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (i_rate) begin
                        if (tick_q == MID_TICK) begin
                            tick_q <= '0;
                            if (!rx_s) begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end else begin
                                // Line went back high before mid start bit: a glitch.
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_rate) begin
                        if (tick_q == BIT_TICK) begin
                            tick_q  <= '0;
                            shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
                            if (bit_q == LAST_BIT) begin
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + BIT_ONE;
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (i_rate) begin
                        if (tick_q == SB_LAST) begin
                            tick_q  <= '0;
                            state_q <= IDLE;
                            if (rx_s) begin
                                o_data    <= shift_q;
                                o_rx_done <= 1'b1;
                            end else begin
                                o_frame_error <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tick_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter NB_DATA, default 8: number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16: oversampling ticks spanning one stop bit.
REQ-003 Parameter N_SYNC, default 2: number of flip-flops in the i_rx synchronizer.
REQ-004 i_clock  input  1  system clock; all state updates on its rising edge.
REQ-005 i_reset  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 i_rate  input  1  16x-baud oversampling tick, one-cycle-high pulse from the baud rate generator.
REQ-007 i_rx  input  1  asynchronous serial line, idle high.
REQ-008 o_data  output  NB_DATA  last correctly received word.
REQ-009 o_rx_done  output  1  one-cycle pulse when o_data is updated.
REQ-010 o_frame_error  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-011 i_rx SHALL pass through an N_SYNC-stage synchronizer reset to 1; all decisions use the synchronized value rx_s.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP, plus a 4-bit tick counter and a $clog2(NB_DATA)-bit bit counter.
REQ-013 The tick counter SHALL advance only in cycles where i_rate=1; cycles without a tick hold all counters.
REQ-014 IDLE: when rx_s=0 -> START with tick counter=0, independent of i_rate.
REQ-015 START: on the tick where the counter equals 7 (mid start bit), rx_s=0 -> DATA with tick counter=0 and bit counter=0; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: on the tick where the counter equals 15, shift rx_s into the MSB of a shift register (LSB-first line order) and clear the tick counter.
REQ-017 DATA: after the sample of bit NB_DATA-1 -> STOP with tick counter=0; otherwise increment the bit counter.
REQ-018 STOP: on the tick where the counter equals SB_TICK-1, sample rx_s and return to IDLE.
REQ-019 STOP sample rx_s=1: load o_data from the shift register and assert o_rx_done for exactly one cycle.
REQ-020 STOP sample rx_s=0: o_data holds, o_rx_done stays 0, and o_frame_error asserts for exactly one cycle.
REQ-021 o_rx_done and o_frame_error SHALL never be high in the same cycle, and SHALL be registered outputs.
REQ-022 After a STOP exit, a start edge already present in the IDLE cycle SHALL be accepted (back-to-back frames).
REQ-023 i_rx changes outside the sample points SHALL NOT affect state.
REQ-024 Ticks in IDLE SHALL be ignored, and the tick counter SHALL stay 0.

Reset
REQ-025 i_reset=0 SHALL asynchronously force state=IDLE, all counters=0, shift register=0, o_data=0, o_rx_done=0, o_frame_error=0, and synchronizer stages=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release the block waits in IDLE for a new falling edge.
REQ-027 Release of i_reset SHALL take effect on the next rising i_clock edge; no state change occurs in the same cycle as release.

Verification
REQ-028 Setup: i_rate pulses every 4th clock, bit time = 64 clocks; send 0x55 with a valid stop bit -> one o_rx_done pulse, o_data=0x55, o_frame_error=0.
REQ-029 Back-to-back frames 0xA3 then 0x0F, with no idle gap -> two o_rx_done pulses in order, o_data=0xA3 then 0x0F.
REQ-030 Low glitch on i_rx of 5 ticks (20 clocks) from idle -> FSM returns to IDLE, no pulses, o_data unchanged.
REQ-031 Frame 0x3C with the stop bit held low -> o_frame_error pulses once, o_rx_done stays 0, o_data keeps its previous value.
REQ-032 i_reset pulled low at data bit 4 of 0xFF, released, then 0x81 sent -> no pulse for the aborted frame; o_data=0x81 with one o_rx_done.
REQ-033 i_rate held 0 for 100 clocks mid-DATA -> counters frozen; on tick resume the frame completes with the correct word.
